// File: rtl/dnnbp_pkg.sv
// Shared types and fixed-point helpers for the backprop delta engines.
package dnnbp_pkg;

  // Engine sequencing: capture a job, accumulate one product per cycle,
  // scale by the sigmoid derivative, then hold the result until consumed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Fixed-point 1.0 for a given number of fractional bits.
  function automatic longint fx_one(input int frac);
    return 64'sd1 <<< frac;
  endfunction

  // Largest positive two's-complement value of the given width (width <= 63).
  function automatic longint fx_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative two's-complement value of the given width (width <= 63).
  function automatic longint fx_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/fx_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic shift right by
// FRAC (rounds toward -inf), saturated back to WIDTH bits.
module fx_mul #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] full;
  logic signed [2*WIDTH-1:0] shifted;
  logic                      ovf;

  // Product, rescale, and clamp when the rescaled value leaves WIDTH range.
  always_comb begin
    full    = a * b;
    shifted = full >>> FRAC;
    // In range only when every bit above the result's sign bit matches it.
    ovf     = !((&shifted[2*WIDTH-1:WIDTH-1]) || !(|shifted[2*WIDTH-1:WIDTH-1]));
    p       = shifted[WIDTH-1:0];
    if (ovf) begin
      p = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/delta_h_seq.sv
// Sequential hidden-layer delta engine:
//   delta = sat(sum_k d_k*w_k) * a*(1-a), one product per cycle,
// with a one-job input buffer, valid/ready on both sides and optional
// accumulation of successive deltas into the held output.
module delta_h_seq
  import dnnbp_pkg::*;
#(
  parameter int NUM   = 2,
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [NUM*WIDTH-1:0]   i_prevd,
  input  logic [NUM*WIDTH-1:0]   i_w,
  input  logic [WIDTH-1:0]       i_a,
  input  logic                   i_acc_en,
  input  logic                   i_clr,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       o_delta
);

  localparam int KW   = $clog2(NUM) + 1;
  localparam int ACCW = WIDTH + $clog2(NUM) + 1;

  localparam logic        [WIDTH-1:0] ONE     = WIDTH'(fx_one(FRAC));
  localparam logic signed [WIDTH-1:0] W_MAX   = WIDTH'(fx_max(WIDTH));
  localparam logic signed [WIDTH-1:0] W_MIN   = WIDTH'(fx_min(WIDTH));
  localparam logic signed [ACCW-1:0]  ACC_MAX = ACCW'(fx_max(WIDTH));
  localparam logic signed [ACCW-1:0]  ACC_MIN = ACCW'(fx_min(WIDTH));
  localparam logic signed [WIDTH:0]   SUM_MAX = (WIDTH+1)'(fx_max(WIDTH));
  localparam logic signed [WIDTH:0]   SUM_MIN = (WIDTH+1)'(fx_min(WIDTH));

  state_t                   state_reg, state_next;
  logic [NUM*WIDTH-1:0]     prevd_reg, w_reg;
  logic [WIDTH-1:0]         a_reg;
  logic                     acc_en_reg;
  logic signed [ACCW-1:0]   acc_reg;
  logic [KW-1:0]            k_reg;
  logic                     valid_reg;
  logic [WIDTH-1:0]         delta_reg;

  logic signed [WIDTH-1:0]  mul0_a, mul0_b, mul0_p;
  logic signed [WIDTH-1:0]  acc_sat, r_val, delta_acc;
  logic signed [WIDTH:0]    delta_sum;
  logic                     last_term;

  assign o_ready   = (state_reg == ST_IDLE);
  assign o_valid   = valid_reg;
  assign o_delta   = delta_reg;
  assign last_term = (k_reg == KW'(NUM - 1));

  // Shared multiplier: d_k*w_k while accumulating, a*(1-a) while scaling.
  always_comb begin
    mul0_a = a_reg;
    mul0_b = ONE - a_reg;
    if (state_reg == ST_MAC) begin
      mul0_a = prevd_reg[int'(k_reg)*WIDTH +: WIDTH];
      mul0_b = w_reg[int'(k_reg)*WIDTH +: WIDTH];
    end
  end

  fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_term (
    .a (mul0_a),
    .b (mul0_b),
    .p (mul0_p)
  );

  fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_scale (
    .a (acc_sat),
    .b (mul0_p),
    .p (r_val)
  );

  // Clamp the wide sum to WIDTH and form the saturated running batch total.
  always_comb begin
    acc_sat = acc_reg[WIDTH-1:0];
    if (acc_reg > ACC_MAX) acc_sat = W_MAX;
    else if (acc_reg < ACC_MIN) acc_sat = W_MIN;
    delta_sum = {delta_reg[WIDTH-1], delta_reg} + {r_val[WIDTH-1], r_val};
    delta_acc = delta_sum[WIDTH-1:0];
    if (delta_sum > SUM_MAX) delta_acc = W_MAX;
    else if (delta_sum < SUM_MIN) delta_acc = W_MIN;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state sequencing.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (i_valid) state_next = ST_MAC;
      ST_MAC:   if (last_term) state_next = ST_SCALE;
      ST_SCALE: state_next = ST_DONE;
      ST_DONE:  if (i_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath: job capture, accumulation, scaling and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevd_reg  <= '0;
      w_reg      <= '0;
      a_reg      <= '0;
      acc_en_reg <= 1'b0;
      acc_reg    <= '0;
      k_reg      <= '0;
      valid_reg  <= 1'b0;
      delta_reg  <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          // Clear lands first so a job accepted on the same edge sees zero.
          if (i_clr) delta_reg <= '0;
          if (i_valid) begin
            prevd_reg  <= i_prevd;
            w_reg      <= i_w;
            a_reg      <= i_a;
            acc_en_reg <= i_acc_en;
            acc_reg    <= '0;
            k_reg      <= '0;
          end
        end
        ST_MAC: begin
          acc_reg <= acc_reg + {{(ACCW-WIDTH){mul0_p[WIDTH-1]}}, mul0_p};
          k_reg   <= k_reg + 1'b1;
        end
        ST_SCALE: begin
          delta_reg <= acc_en_reg ? delta_acc : r_val;
          valid_reg <= 1'b1;
        end
        ST_DONE: begin
          if (i_ready) valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delta_h_seq.sv
// Directed scoreboard bench for delta_h_seq (NUM=2, WIDTH=32, FRAC=16).
module tb_delta_h_seq;

  localparam int NUM   = 2;
  localparam int WIDTH = 32;
  localparam int FRAC  = 16;

  localparam logic [31:0] F1_0  = 32'h0001_0000;
  localparam logic [31:0] F2_0  = 32'h0002_0000;
  localparam logic [31:0] F0_5  = 32'h0000_8000;
  localparam logic [31:0] F0_25 = 32'h0000_4000;
  localparam logic [31:0] FM1_0 = 32'hFFFF_0000;
  localparam logic [31:0] BIG   = 32'h7FFF_0000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_valid, o_ready, i_acc_en, i_clr, o_valid, i_ready;
  logic [NUM*WIDTH-1:0] i_prevd, i_w;
  logic [WIDTH-1:0]     i_a, o_delta;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];

  delta_h_seq #(.NUM(NUM), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_prevd  (i_prevd),
    .i_w      (i_w),
    .i_a      (i_a),
    .i_acc_en (i_acc_en),
    .i_clr    (i_clr),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_delta  (o_delta)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a job for one edge (engine must be idle), push its expected result,
  // then scramble the inputs to prove the engine works from its own copy.
  task automatic start_job(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] a,  input logic acc_en,
                           input logic clr,       input logic [31:0] exp);
    @(negedge clk);
    check("ready_before_accept", {31'b0, o_ready}, 32'd1);
    i_prevd  = {d1, d0};
    i_w      = {w1, w0};
    i_a      = a;
    i_acc_en = acc_en;
    i_clr    = clr;
    i_valid  = 1'b1;
    @(negedge clk);
    i_valid  = 1'b0;
    i_clr    = 1'b0;
    i_acc_en = 1'b0;
    i_prevd  = {$urandom, $urandom};
    i_w      = {$urandom, $urandom};
    i_a      = $urandom;
    sb_q.push_back(exp);
    check("ready_after_accept", {31'b0, o_ready}, 32'd0);
    $display("job accepted d={%h,%h} w={%h,%h} a=%h acc_en=%0b clr=%0b expect=%h",
             d0, d1, w0, w1, a, acc_en, clr, exp);
  endtask

  // Wait (bounded) for the result, compare against the scoreboard, handshake.
  task automatic finish_job(input string tag, input logic chk_lat);
    int cnt;
    logic [31:0] exp;
    cnt = 0;
    while (!o_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (chk_lat) check({tag, "_latency"}, 32'(cnt), 32'(NUM + 1));
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
    check({tag, "_delta"}, o_delta, exp);
    $display("result %s o_delta=%h expected=%h latency=%0d", tag, o_delta, exp, cnt);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'b0, o_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'b0, o_ready}, 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_acc_en = 1'b0;
    i_clr    = 1'b0;
    i_ready  = 1'b0;
    i_prevd  = '0;
    i_w      = '0;
    i_a      = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, o_ready}, 32'd1);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_delta", o_delta, 32'd0);
    rst_n = 1'b1;
    $display("reset released");

    // Basic: sum 1.0, a(1-a)=0.25.
    start_job(F1_0, F2_0, F0_5, F0_25, F0_5, 1'b0, 1'b0, 32'h0000_4000);
    finish_job("basic", 1'b1);

    // Accumulate the same job into the held result.
    start_job(F1_0, F2_0, F0_5, F0_25, F0_5, 1'b1, 1'b0, 32'h0000_8000);
    finish_job("accum", 1'b1);

    // Clear while idle.
    @(negedge clk);
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
    check("clr_delta", o_delta, 32'd0);
    $display("clear applied o_delta=%h", o_delta);

    // Clear plus accumulate-job on the same edge: job sees zero.
    start_job(F1_0, F2_0, F0_5, F0_25, F0_5, 1'b0, 1'b0, 32'h0000_4000);
    finish_job("pre_clr", 1'b1);
    start_job(F1_0, F2_0, F0_5, F0_25, F0_5, 1'b1, 1'b1, 32'h0000_4000);
    finish_job("clr_with_job", 1'b1);

    // Saturation: each product and the sum clamp to max, then times 0.25.
    start_job(BIG, BIG, BIG, BIG, F0_5, 1'b0, 1'b0, 32'h1FFF_FFFF);
    check("sat_no_wrap", {31'b0, o_delta[31]}, 32'd0);
    finish_job("sat", 1'b1);

    // Signed: -1.0 * 1.0 * 0.25.
    start_job(FM1_0, 32'd0, F1_0, 32'd0, F0_5, 1'b0, 1'b0, 32'hFFFF_C000);
    finish_job("signed", 1'b1);

    // Backpressure: result held, new offers ignored.
    start_job(F1_0, F2_0, F0_5, F0_25, F0_5, 1'b0, 1'b0, 32'h0000_4000);
    begin
      int cnt;
      cnt = 0;
      while (!o_valid && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      check("bp_latency", 32'(cnt), 32'(NUM + 1));
    end
    i_prevd  = {FM1_0, FM1_0};
    i_w      = {F1_0, F1_0};
    i_a      = F0_25;
    i_acc_en = 1'b1;
    i_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid_hold", {31'b0, o_valid}, 32'd1);
      check("bp_delta_hold", o_delta, 32'h0000_4000);
      check("bp_ready_low", {31'b0, o_ready}, 32'd0);
    end
    $display("backpressure held 20 cycles o_delta=%h", o_delta);
    i_valid  = 1'b0;
    i_acc_en = 1'b0;
    finish_job("bp", 1'b0);
    start_job(FM1_0, 32'd0, F1_0, 32'd0, F0_5, 1'b0, 1'b0, 32'hFFFF_C000);
    finish_job("after_bp", 1'b1);

    // Reset in the middle of accumulation (k=1).
    start_job(F1_0, F2_0, F0_5, F0_25, F0_5, 1'b0, 1'b0, 32'h0000_4000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, o_valid}, 32'd0);
    check("mid_rst_delta", o_delta, 32'd0);
    check("mid_rst_ready", {31'b0, o_ready}, 32'd1);
    $display("mid-job reset o_valid=%0b o_delta=%h o_ready=%0b", o_valid, o_delta, o_ready);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    start_job(F1_0, F2_0, F0_5, F0_25, F0_5, 1'b0, 1'b0, 32'h0000_4000);
    finish_job("after_rst", 1'b1);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
